// File: rtl/mult_stall_ctrl.sv
// -----------------------------------------------------------------------------
// mult_stall_ctrl
//
// Sequencer for the EX-stage multiply unit of a five-stage MIPS pipeline.
// It runs a radix-2 shift-add multiply over WIDTH cycles for mult, multu,
// madd and msub. While the multiply runs it holds PC, IF/ID and ID/EX. It
// then presents the {Hi,Lo} result with a one-cycle HiLo write strobe in the
// cycle the instruction leaves EX.
//
// Handshake: a start is accepted only in IDLE, when i_mult_start is high, the
// op is mult/multu and i_flush is low. o_mult_valid (== o_hilo_write) is a
// single-cycle pulse in DONE, and the pipeline consumes o_mult_result at the
// rising edge that ends that cycle. There is no back-pressure.
//
// Ports
//   i_clk          pipeline clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_mult_start   EX holds a multiply-class op (sampled in IDLE only)
//   i_mult_op      00 none, 01 mult (signed), 10 multu, 11 none
//   i_mult_acc     00 product, 01 madd, 10 msub, 11 product
//   i_op_a/i_op_b  rs/rt operands
//   i_hilo_in      forwarded {Hi,Lo} used by madd/msub
//   i_flush        kill the EX-stage instruction
//   o_stall        hold PC, IF/ID, ID/EX
//   o_busy         FSM is in BUSY
//   o_mult_valid   o_mult_result valid this cycle
//   o_hilo_write   HiLo write strobe, equal to o_mult_valid
//   o_mult_result  registered {Hi,Lo} result
//   o_dbg_state    FSM state (00 IDLE, 01 BUSY, 10 DONE)
//   o_dbg_count    iteration counter
// -----------------------------------------------------------------------------
module mult_stall_ctrl #(
   parameter int WIDTH = 32,
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_mult_start,
   input  logic [1:0]           i_mult_op,
   input  logic [1:0]           i_mult_acc,
   input  logic [WIDTH-1:0]     i_op_a,
   input  logic [WIDTH-1:0]     i_op_b,
   input  logic [2*WIDTH-1:0]   i_hilo_in,
   input  logic                 i_flush,
   output logic                 o_stall,
   output logic                 o_busy,
   output logic                 o_mult_valid,
   output logic                 o_hilo_write,
   output logic [2*WIDTH-1:0]   o_mult_result,
   output logic [1:0]           o_dbg_state,
   output logic [CW-1:0]        o_dbg_count
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_BUSY = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_MULTU = 2'b10;

   localparam logic [1:0] ACC_MADD = 2'b01;
   localparam logic [1:0] ACC_MSUB = 2'b10;

   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   logic [1:0]          r_state;
   logic [CW-1:0]       r_count;
   logic [2*WIDTH-1:0]  r_mcand;     // multiplicand, shifts left each step
   logic [WIDTH-1:0]    r_mplier;    // multiplier, shifts right each step
   logic [2*WIDTH-1:0]  r_acc;
   logic                r_sign;
   logic [1:0]          r_acc_mode;
   logic [2*WIDTH-1:0]  r_hilo;
   logic [2*WIDTH-1:0]  r_result;

   logic                w_op_valid;
   logic                w_signed;
   logic                w_start;
   logic [WIDTH-1:0]    w_mag_a;
   logic [WIDTH-1:0]    w_mag_b;
   logic                w_sign;
   logic [2*WIDTH-1:0]  w_acc_step;
   logic [2*WIDTH-1:0]  w_final;
   logic [2*WIDTH-1:0]  w_hilo_next;
   logic                w_last;

   assign w_op_valid = (i_mult_op == OP_MULT) || (i_mult_op == OP_MULTU);
   assign w_signed   = (i_mult_op == OP_MULT);

   // Gated by i_rst_n so o_stall drops together with every other output
   // while reset is asserted, even if a start request is being presented.
   assign w_start = i_rst_n && (r_state == S_IDLE) && i_mult_start &&
                    w_op_valid && !i_flush;

   // Magnitudes are unsigned WIDTH-bit values: -2^(WIDTH-1) maps to
   // 2^(WIDTH-1), which still fits, so the most negative operand is exact.
   assign w_mag_a = (w_signed && i_op_a[WIDTH-1]) ? (-i_op_a) : i_op_a;
   assign w_mag_b = (w_signed && i_op_b[WIDTH-1]) ? (-i_op_b) : i_op_b;
   assign w_sign  = w_signed && (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);

   // Accumulator value after the current iteration; used both for the normal
   // update and to form the final result on the last iteration.
   assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_final    = r_sign ? (-w_acc_step) : w_acc_step;
   assign w_last     = (r_count == LAST_COUNT);

   always_comb begin
      w_hilo_next = w_final;
      case (r_acc_mode)
         ACC_MADD: w_hilo_next = r_hilo + w_final;
         ACC_MSUB: w_hilo_next = r_hilo - w_final;
         default:  w_hilo_next = w_final;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_acc      <= '0;
         r_sign     <= 1'b0;
         r_acc_mode <= 2'b00;
         r_hilo     <= '0;
         r_result   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_mcand    <= {{WIDTH{1'b0}}, w_mag_a};
                  r_mplier   <= w_mag_b;
                  r_acc      <= '0;
                  r_sign     <= w_sign;
                  r_acc_mode <= i_mult_acc;
                  r_hilo     <= i_hilo_in;
                  r_count    <= '0;
                  r_state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (i_flush) begin
                  // Killed instruction: abandon the multiply, keep the old result.
                  r_state <= S_IDLE;
               end else begin
                  r_acc    <= w_acc_step;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_count  <= r_count + 1'b1;
                  if (w_last) begin
                     r_result <= w_hilo_next;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // One cycle only; a start request here is not considered.
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_busy        = (r_state == S_BUSY);
   assign o_stall       = w_start || o_busy;
   assign o_mult_valid  = (r_state == S_DONE) && !i_flush;
   assign o_hilo_write  = o_mult_valid;
   assign o_mult_result = r_result;
   assign o_dbg_state   = r_state;
   assign o_dbg_count   = r_count;

endmodule

// File: doc/mult_stall_ctrl.md
# mult_stall_ctrl

Sequencer for the EX-stage multiply unit of the five-stage MIPS pipeline. It runs a radix-2 shift-add multiply over 32 cycles for mult, multu, madd and msub. While the multiply runs it stalls PC, IF/ID and ID/EX. It then presents the 64-bit result, with a one-cycle HiLo write strobe, to the EX/MEM register in the cycle the instruction leaves EX.

## Interface
- WIDTH, 32, operand width; product and HiLo are 2*WIDTH.
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MultStart  in  1  level: instruction in EX is a multiply-class op; sampled only in IDLE.
- MultOp  in  2  00 none, 01 mult (signed), 10 multu, 11 reserved (treated as none).
- MultAcc  in  2  00 write product, 01 madd (HiLo + product), 10 msub (HiLo − product), 11 as 00.
- OpA, OpB  in  WIDTH  rs/rt operands.
- HiLoIn  in  2*WIDTH  current (forwarded) {Hi,Lo}.
- Flush  in  1  kill the EX-stage instruction.
- Stall  out  1  hold PC, IF/ID, ID/EX.
- Busy  out  1  state is BUSY.
- MultValid  out  1  MultResult valid this cycle.
- HiLoWrite  out  1  write strobe to EX/MEM HiLoWrite field; equals MultValid.
- MultResult  out  2*WIDTH  {Hi,Lo} result, registered.

## Operation
- Reset values: state IDLE, count 0, Stall 0, Busy 0, MultValid 0, HiLoWrite 0, MultResult 0. All internal operand, accumulator and sign registers are 0.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - Start condition: MultStart=1, MultOp∈{01,10} and Flush=0.
  - When the start condition holds, Stall=1 combinationally.
  - At the edge where it holds: latch the magnitudes of OpA and OpB, the result sign, MultAcc and HiLoIn. Clear the product accumulator. Set count=0. Go to BUSY.
  - Magnitude is the two's-complement absolute value for mult; the raw value for multu.
  - Result sign = OpA[WIDTH-1] XOR OpB[WIDTH-1] for mult; 0 for multu.
- BUSY:
  - Stall=1 and Busy=1.
  - Each edge: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator. Then shift the multiplicand left, shift the multiplier right, and increment count.
  - At the edge where count=WIDTH-1, the last iteration completes. Form final = sign ? −acc : acc. Apply MultAcc (wrap mod 2^(2*WIDTH)). Register the result into MultResult. Go to DONE.
- DONE:
  - Stall=0, MultValid=1, HiLoWrite=1.
  - The instruction advances and EX/MEM captures MultResult at this edge.
  - Next state is IDLE unconditionally. MultStart is ignored in this state.
- Flush:
  - In BUSY or DONE: next state IDLE. MultValid and HiLoWrite are forced 0 in the cycle Flush is high. MultResult holds its old value.
  - In IDLE: Flush blocks the start and Stall=0.
- MultStart is ignored in BUSY and DONE. MultOp 00 or 11 never starts.
- Edge cases:
  - −2^(WIDTH−1) × −2^(WIDTH−1) gives magnitude 2^(2*WIDTH−2), with no overflow.
  - A zero operand still takes the full WIDTH iterations.
- rst_n low at any time forces all reset values immediately, independent of clk.

## Timing
- Cycle 0 is the IDLE cycle with a valid start: Stall=1.
- Cycles 1..WIDTH are BUSY: Stall=1, Busy=1.
- Cycle WIDTH+1 is DONE: MultValid=1, Stall=0. MultResult is stable for the whole cycle.
- Total Stall-high cycles = WIDTH+1 (33). Start-to-valid latency = WIDTH+1.
- A back-to-back multiply can start at the earliest in cycle WIDTH+2, the first IDLE cycle.
- MultValid and HiLoWrite are always single-cycle pulses.

## Test plan
- Signed mult: mult OpA=3, OpB=0xFFFFFFFB (−5), MultAcc=00 → Stall high for cycles 0..32. In cycle 33: MultValid=1 for exactly 1 cycle, MultResult=0xFFFFFFFF_FFFFFFF1.
- Unsigned and corner operands:
  - multu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001.
  - mult 0x80000000 × 0x80000000 → 0x40000000_00000000.
  - mult 0 × 0x1234 → 0 after the full 33 cycles.
- Accumulate:
  - madd with HiLoIn=0x00000000_00000010, operands 4 × 4 → 0x00000000_00000020.
  - msub with HiLoIn=0, operands 1 × 1 → 0xFFFFFFFF_FFFFFFFF (wrap).
- Flush and reset:
  - Flush on the 10th BUSY cycle → IDLE next cycle, Stall=0, no MultValid pulse.
  - rst_n low mid-BUSY → all outputs 0 immediately; after release, a new mult runs correctly.
- Back-to-back: two mults with MultStart held high across DONE → no restart in DONE. The second starts in cycle 34 and its MultValid appears in cycle 67, with the correct second product.
- Non-start: MultOp=11 or MultOp=00 with MultStart=1, or Flush=1 together with a valid start → Stall stays 0 and state stays IDLE.
